// File: rtl/board_update_scheduler.sv
`default_nettype none
// ============================================================================
// board_update_scheduler: queues board-square writes and drains whole groups
// into the board RAM write port.  Optional BOARD_SCHED_VBLANK_ONLY_EN gates
// draining to vertical blanking.  Revision: 1.0
// ============================================================================
module board_update_scheduler #(
    parameter int DEPTH = 4,
    parameter int SQ_W  = 6,
    parameter int PC_W  = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            vblank,
    input  logic            wr_valid,
    output logic            wr_ready,
    input  logic [SQ_W-1:0] wr_sq,
    input  logic [PC_W-1:0] wr_piece,
    input  logic            wr_last,
    output logic            mem_we,
    output logic [SQ_W-1:0] mem_addr,
    output logic [PC_W-1:0] mem_wdata,
    output logic            update_done,
    output logic            err_ovf
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRAIN = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t          r_state;
    logic [SQ_W-1:0] r_sq_mem [DEPTH];
    logic [PC_W-1:0] r_pc_mem [DEPTH];
    logic [DEPTH-1:0] r_last_mem;
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic [CW-1:0]   r_groups;
    logic            r_cur_last;

    logic            w_gate;
    logic            w_full;
    logic            w_ovf;
    logic            w_head_last;
    logic            w_pop;
    logic            w_push;
    logic [CW-1:0]   w_count_next;
    logic [CW-1:0]   w_groups_next;

`ifdef BOARD_SCHED_VBLANK_ONLY_EN
    assign w_gate = vblank;
`else
    // Free-running drain; vblank is read but has no effect in this mode.
    assign w_gate = vblank | 1'b1;
`endif

    assign w_full      = (r_count == CW'(DEPTH));
    assign w_ovf       = w_full && (r_groups == '0);
    assign w_head_last = r_last_mem[r_rd_ptr];

    // A group in flight keeps popping; only a finished group may stop the burst.
    always_comb begin
        w_pop = 1'b0;
        case (r_state)
            S_IDLE:  w_pop = w_gate && (r_groups != '0);
            S_DRAIN: w_pop = !(r_cur_last && ((r_groups == '0) || !w_gate));
            default: w_pop = 1'b0;
        endcase
        if (w_ovf) begin
            w_pop = 1'b0;
        end
    end

    // A pop frees a slot at the edge, so a full queue still takes a push then.
    assign w_push        = wr_valid && (wr_ready || w_pop) && !w_ovf;
    assign w_count_next  = r_count + CW'(w_push) - CW'(w_pop);
    assign w_groups_next = r_groups + CW'(w_push && wr_last) - CW'(w_pop && w_head_last);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_sq_mem[r_wr_ptr]   <= wr_sq;
            r_pc_mem[r_wr_ptr]   <= wr_piece;
            r_last_mem[r_wr_ptr] <= wr_last;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_groups    <= '0;
            r_cur_last  <= 1'b0;
            wr_ready    <= 1'b1;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            update_done <= 1'b0;
            err_ovf     <= 1'b0;
        end else if (w_ovf) begin
            r_state     <= S_IDLE;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_groups    <= '0;
            r_cur_last  <= 1'b0;
            wr_ready    <= 1'b1;
            mem_we      <= 1'b0;
            update_done <= 1'b0;
            err_ovf     <= 1'b1;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr   <= r_rd_ptr + 1'b1;
                mem_addr   <= r_sq_mem[r_rd_ptr];
                mem_wdata  <= r_pc_mem[r_rd_ptr];
                r_cur_last <= w_head_last;
            end
            r_count     <= w_count_next;
            r_groups    <= w_groups_next;
            wr_ready    <= (w_count_next != CW'(DEPTH));
            mem_we      <= w_pop;
            update_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (!w_pop) begin
                        r_state     <= S_DONE;
                        update_done <= 1'b1;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_board_update_scheduler.sv
`default_nettype none
// ============================================================================
// tb_board_update_scheduler: scoreboard bench for board_update_scheduler.
// Revision: 1.0
// ============================================================================
module tb_board_update_scheduler;
    logic       clk = 1'b0;
    logic       reset_n;
    logic       vblank;
    logic       wr_valid;
    logic       wr_ready;
    logic [5:0] wr_sq;
    logic [3:0] wr_piece;
    logic       wr_last;
    logic       mem_we;
    logic [5:0] mem_addr;
    logic [3:0] mem_wdata;
    logic       update_done;
    logic       err_ovf;

    int n_cmp = 0;
    int n_err = 0;
    logic [9:0] exp_q[$];

    board_update_scheduler #(.DEPTH(4), .SQ_W(6), .PC_W(4)) dut (
        .clk(clk), .reset_n(reset_n), .vblank(vblank),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_sq(wr_sq),
        .wr_piece(wr_piece), .wr_last(wr_last), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .update_done(update_done), .err_ovf(err_ovf)
    );

    always #5 clk = ~clk;

    // Every RAM write must match the oldest expected entry.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected_write: got addr=%0d data=%0d, required no write", mem_addr, mem_wdata);
            end else begin
                logic [9:0] e;
                e = exp_q.pop_front();
                if ({mem_addr, mem_wdata} !== e) begin
                    n_err++;
                    $display("FAIL sb_write: got addr=%0d data=%0d, required addr=%0d data=%0d",
                             mem_addr, mem_wdata, e[9:4], e[3:0]);
                end
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [5:0] sq, input logic [3:0] pc, input logic last, input bit will_write);
        wr_valid = 1'b1;
        wr_sq    = sq;
        wr_piece = pc;
        wr_last  = last;
        if (will_write) exp_q.push_back({sq, pc});
        step();
        wr_valid = 1'b0;
    endtask

    task automatic test_reset;
        reset_n = 1'b0; vblank = 1'b0; wr_valid = 1'b0;
        wr_sq = '0; wr_piece = '0; wr_last = 1'b0;
        step(3);
        n_cmp++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL rst_mem_we: got %b required 0", mem_we); end
        n_cmp++; if (mem_addr !== 6'd0) begin n_err++; $display("FAIL rst_mem_addr: got %0d required 0", mem_addr); end
        n_cmp++; if (mem_wdata !== 4'd0) begin n_err++; $display("FAIL rst_mem_wdata: got %0d required 0", mem_wdata); end
        n_cmp++; if (update_done !== 1'b0) begin n_err++; $display("FAIL rst_update_done: got %b required 0", update_done); end
        n_cmp++; if (err_ovf !== 1'b0) begin n_err++; $display("FAIL rst_err_ovf: got %b required 0", err_ovf); end
        n_cmp++; if (wr_ready !== 1'b1) begin n_err++; $display("FAIL rst_wr_ready: got %b required 1", wr_ready); end
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_gate_open;
        vblank = 1'b0;
        push(6'd12, 4'd0, 1'b0, 1'b1);
        push(6'd28, 4'd5, 1'b1, 1'b1);
`ifdef BOARD_SCHED_VBLANK_ONLY_EN
        repeat (3) begin
            n_cmp++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL gate_closed_we: got %b required 0", mem_we); end
            step();
        end
        vblank = 1'b1;
`endif
        n_cmp++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL gate_decide_we: got %b required 0", mem_we); end
        step();
        n_cmp++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 6'd12, 4'd0}) begin
            n_err++; $display("FAIL gate_write1: got we=%b addr=%0d data=%0d required we=1 addr=12 data=0", mem_we, mem_addr, mem_wdata); end
        step();
        n_cmp++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 6'd28, 4'd5}) begin
            n_err++; $display("FAIL gate_write2: got we=%b addr=%0d data=%0d required we=1 addr=28 data=5", mem_we, mem_addr, mem_wdata); end
        step();
        n_cmp++; if ({mem_we, update_done} !== 2'b01) begin
            n_err++; $display("FAIL gate_done: got we=%b done=%b required we=0 done=1", mem_we, update_done); end
        step();
        n_cmp++; if (update_done !== 1'b0) begin n_err++; $display("FAIL gate_done_pulse: got %b required 0", update_done); end
        vblank = 1'b0;
    endtask

    task automatic test_incomplete;
        int w;
        w = 0;
        vblank = 1'b1;
        push(6'd3, 4'd7, 1'b0, 1'b1);
        repeat (20) begin
            if (mem_we === 1'b1) w++;
            step();
        end
        n_cmp++; if (w != 0) begin n_err++; $display("FAIL incomplete_no_write: got %0d writes required 0", w); end
        n_cmp++; if (wr_ready !== 1'b1) begin n_err++; $display("FAIL incomplete_ready: got %b required 1", wr_ready); end
        push(6'd4, 4'd0, 1'b1, 1'b1);
        step();
        n_cmp++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 6'd3, 4'd7}) begin
            n_err++; $display("FAIL incomplete_write1: got we=%b addr=%0d data=%0d required we=1 addr=3 data=7", mem_we, mem_addr, mem_wdata); end
        step();
        n_cmp++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 6'd4, 4'd0}) begin
            n_err++; $display("FAIL incomplete_write2: got we=%b addr=%0d data=%0d required we=1 addr=4 data=0", mem_we, mem_addr, mem_wdata); end
        step();
        n_cmp++; if (update_done !== 1'b1) begin n_err++; $display("FAIL incomplete_done: got %b required 1", update_done); end
        step();
    endtask

    task automatic test_group_boundary;
`ifdef BOARD_SCHED_VBLANK_ONLY_EN
        int w;
        w = 0;
        vblank = 1'b0;
        push(6'd10, 4'd1, 1'b0, 1'b1);
        push(6'd11, 4'd2, 1'b1, 1'b1);
        push(6'd20, 4'd3, 1'b0, 1'b1);
        push(6'd21, 4'd4, 1'b1, 1'b1);
        vblank = 1'b1;
        step();
        n_cmp++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 6'd10, 4'd1}) begin
            n_err++; $display("FAIL bound_a1: got we=%b addr=%0d data=%0d required we=1 addr=10 data=1", mem_we, mem_addr, mem_wdata); end
        vblank = 1'b0;
        step();
        n_cmp++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 6'd11, 4'd2}) begin
            n_err++; $display("FAIL bound_a2: got we=%b addr=%0d data=%0d required we=1 addr=11 data=2", mem_we, mem_addr, mem_wdata); end
        step();
        n_cmp++; if ({mem_we, update_done} !== 2'b01) begin
            n_err++; $display("FAIL bound_done: got we=%b done=%b required we=0 done=1", mem_we, update_done); end
        repeat (8) begin
            step();
            if (mem_we === 1'b1) w++;
        end
        n_cmp++; if (w != 0) begin n_err++; $display("FAIL bound_wait: got %0d writes required 0", w); end
        vblank = 1'b1;
        step(2);
        n_cmp++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 6'd20, 4'd3}) begin
            n_err++; $display("FAIL bound_b1: got we=%b addr=%0d data=%0d required we=1 addr=20 data=3", mem_we, mem_addr, mem_wdata); end
        step();
        n_cmp++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 6'd21, 4'd4}) begin
            n_err++; $display("FAIL bound_b2: got we=%b addr=%0d data=%0d required we=1 addr=21 data=4", mem_we, mem_addr, mem_wdata); end
        step();
        n_cmp++; if (update_done !== 1'b1) begin n_err++; $display("FAIL bound_done2: got %b required 1", update_done); end
        step();
`else
        // Two groups pushed back to back drain as one unbroken burst.
        push(6'd10, 4'd1, 1'b0, 1'b1);
        push(6'd11, 4'd2, 1'b1, 1'b1);
        push(6'd20, 4'd3, 1'b0, 1'b1);
        push(6'd21, 4'd4, 1'b1, 1'b1);
        n_cmp++; if ({mem_we, mem_addr, mem_wdata, update_done} !== {1'b1, 6'd11, 4'd2, 1'b0}) begin
            n_err++; $display("FAIL bound_a2: got we=%b addr=%0d data=%0d done=%b required we=1 addr=11 data=2 done=0", mem_we, mem_addr, mem_wdata, update_done); end
        step();
        n_cmp++; if ({mem_we, mem_addr, mem_wdata, update_done} !== {1'b1, 6'd20, 4'd3, 1'b0}) begin
            n_err++; $display("FAIL bound_b1: got we=%b addr=%0d data=%0d done=%b required we=1 addr=20 data=3 done=0", mem_we, mem_addr, mem_wdata, update_done); end
        step();
        n_cmp++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 6'd21, 4'd4}) begin
            n_err++; $display("FAIL bound_b2: got we=%b addr=%0d data=%0d required we=1 addr=21 data=4", mem_we, mem_addr, mem_wdata); end
        step();
        n_cmp++; if ({mem_we, update_done} !== 2'b01) begin
            n_err++; $display("FAIL bound_done: got we=%b done=%b required we=0 done=1", mem_we, update_done); end
        step();
`endif
    endtask

    task automatic test_overflow;
        vblank = 1'b1;
        for (int i = 0; i < 4; i++) push(6'(30 + i), 4'(i), 1'b0, 1'b0);
        n_cmp++; if (wr_ready !== 1'b0) begin n_err++; $display("FAIL ovf_full_ready: got %b required 0", wr_ready); end
        n_cmp++; if (err_ovf !== 1'b0) begin n_err++; $display("FAIL ovf_early: got %b required 0", err_ovf); end
        step();
        n_cmp++; if (err_ovf !== 1'b1) begin n_err++; $display("FAIL ovf_set: got %b required 1", err_ovf); end
        n_cmp++; if (wr_ready !== 1'b1) begin n_err++; $display("FAIL ovf_flush_ready: got %b required 1", wr_ready); end
        step(5);
        push(6'd9, 4'd1, 1'b1, 1'b1);
        step(4);
        n_cmp++; if (err_ovf !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b required 1", err_ovf); end
    endtask

    task automatic test_reset_mid_drain;
        int w;
        w = 0;
        vblank = 1'b1;
        push(6'd40, 4'd1, 1'b0, 1'b1);
        push(6'd41, 4'd2, 1'b0, 1'b1);
        push(6'd42, 4'd3, 1'b1, 1'b0);
        step(2);
        n_cmp++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 6'd41, 4'd2}) begin
            n_err++; $display("FAIL rstmid_write2: got we=%b addr=%0d data=%0d required we=1 addr=41 data=2", mem_we, mem_addr, mem_wdata); end
        reset_n = 1'b0;
        step();
        n_cmp++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL rstmid_we: got %b required 0", mem_we); end
        n_cmp++; if (err_ovf !== 1'b0) begin n_err++; $display("FAIL rstmid_ovf_clear: got %b required 0", err_ovf); end
        step();
        reset_n = 1'b1;
        repeat (12) begin
            step();
            if (mem_we === 1'b1) w++;
        end
        n_cmp++; if (w != 0) begin n_err++; $display("FAIL rstmid_no_write: got %0d writes required 0", w); end
        n_cmp++; if (wr_ready !== 1'b1) begin n_err++; $display("FAIL rstmid_ready: got %b required 1", wr_ready); end
        vblank = 1'b0;
    endtask

    task automatic test_back_to_back;
        int w, d, first, last_w, cyc;
        w = 0; d = 0; first = -1; last_w = -1; cyc = 0;
        vblank = 1'b0;
        push(6'd50, 4'd1, 1'b0, 1'b1);
        push(6'd51, 4'd2, 1'b0, 1'b1);
        push(6'd52, 4'd3, 1'b0, 1'b1);
        push(6'd53, 4'd4, 1'b1, 1'b1);
        n_cmp++; if (wr_ready !== 1'b0) begin n_err++; $display("FAIL b2b_full: got %b required 0", wr_ready); end
        vblank = 1'b1;
        for (int k = 0; k < 6; k++) begin
            wr_valid = 1'b1;
            wr_sq    = 6'(56 + k);
            wr_piece = 4'(k);
            wr_last  = 1'b1;
            exp_q.push_back({wr_sq, wr_piece});
            step();
            cyc++;
            if (mem_we === 1'b1) begin w++; if (first < 0) first = cyc; last_w = cyc; end
            if (update_done === 1'b1) d++;
        end
        wr_valid = 1'b0;
        repeat (12) begin
            step();
            cyc++;
            if (mem_we === 1'b1) begin w++; if (first < 0) first = cyc; last_w = cyc; end
            if (update_done === 1'b1) d++;
        end
        n_cmp++; if (w != 10) begin n_err++; $display("FAIL b2b_writes: got %0d required 10", w); end
        n_cmp++; if (last_w - first + 1 != 10) begin n_err++; $display("FAIL b2b_contiguous: got span %0d required 10", last_w - first + 1); end
        n_cmp++; if (d != 1) begin n_err++; $display("FAIL b2b_done: got %0d pulses required 1", d); end
        vblank = 1'b0;
    endtask

    initial begin
        test_reset();
        test_gate_open();
        test_incomplete();
        test_group_boundary();
        test_overflow();
        test_reset_mid_drain();
        test_back_to_back();
        step(2);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL sb_drained: got %0d pending writes required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/board_update_scheduler.md
# board_update_scheduler

Sequences chess-move writes from game logic into the board-state RAM that the VGA renderer scans. Buffers square updates in a small queue and drains them into the RAM write port only during vertical blanking, so a frame never shows half a move. Sits between the game FSM and the write port of the dual-port board RAM; the renderer keeps the read port.

## Interface
Parameters:
- DEPTH, 4: queue entries (power of two, ≥2); the largest allowed group is DEPTH entries.
- SQ_W, 6: square address width (64 squares).
- PC_W, 4: piece code width.

Ports:
- clk  in  1  system clock, 50 MHz domain of the VGA timing.
- reset_n  in  1  reset, synchronous, active-low.
- vblank  in  1  high while the VGA vertical counter is outside the active region.
- wr_valid  in  1  game logic offers an update.
- wr_ready  out  1  queue can accept an update.
- wr_sq  in  SQ_W  target square.
- wr_piece  in  PC_W  piece code to store.
- wr_last  in  1  marks the final entry of an atomic group, for example a move's clear and set.
- mem_we  out  1  board RAM write enable.
- mem_addr  out  SQ_W  board RAM write address.
- mem_wdata  out  PC_W  board RAM write data.
- update_done  out  1  one-cycle pulse when a drain burst ends.
- err_ovf  out  1  sticky; queue filled with no complete group.

## Operation
- The queue is a FIFO of {sq, piece, last}, DEPTH entries deep. An entry is pushed when wr_valid and wr_ready are both high.
- wr_ready = !full.
- groups counts the entries in the queue whose last = 1. A push with last = 1 increments it; a pop with last = 1 decrements it. A simultaneous push and pop of last entries leaves it unchanged.
- The FSM has three states: IDLE, DRAIN and DONE.
- IDLE → DRAIN when the drain gate is open and groups > 0.
- DRAIN pops one entry per cycle and drives the mem_* signals from the popped entry.
- When the popped entry has last = 1, DRAIN checks whether a further group can start:
  - If groups becomes 0, or the drain gate is closed, DRAIN → DONE.
  - Otherwise DRAIN stays in DRAIN and continues.
- Inside a group, DRAIN never stops early, even if the gate closes. A group is always written contiguously.
- DONE asserts update_done for one cycle, then goes to IDLE.
- Incomplete groups, meaning trailing entries without last, stay queued. They are never drained.
- Overflow: if full and groups == 0 in any state, then:
  - err_ovf is set;
  - the queue is flushed (pointers and count zeroed);
  - the FSM goes to IDLE.
  - err_ovf clears only on reset.
- A push is still accepted in the same cycle as a pop when full, because the pop frees space at the cycle edge and wr_ready reflects the pre-pop state. A push into a full queue while no pop is happening is not accepted.

## Timing
- All outputs are registered.
- Reset values: mem_we = 0, mem_addr = 0, mem_wdata = 0, update_done = 0, err_ovf = 0, wr_ready = 1. The queue is empty and the FSM is in IDLE.
- Reset mid-drain: the next cycle has mem_we = 0. All queued entries are discarded, including partially written groups.
- The IDLE → DRAIN decision is made in cycle N. mem_we = 1 with the first entry appears in cycle N+1.
- A group of k entries produces k consecutive mem_we cycles. update_done follows one cycle after the last write.
- The earliest possible write is 2 cycles after the push of a last entry while the gate is open: 1 cycle of push into the FIFO, then the IDLE decision.
- vblank is sampled directly with no edge detection. A drain may start anywhere inside the blanking interval.

## Configuration
- BOARD_SCHED_VBLANK_ONLY_EN defined: drain gate = vblank.
- BOARD_SCHED_VBLANK_ONLY_EN undefined: drain gate = 1. Complete groups drain as soon as they exist, and vblank is ignored. This mode is for simulation and bring-up without VGA timing.
- All other behaviour is identical in both modes.

## Test plan
- Gate open case: with vblank = 0, push {12, 0, 0} and {28, 5, 1}. Result: no mem_we. Raise vblank. Result: mem_we on two consecutive cycles with (12, 0) then (28, 5), update_done pulses the next cycle, and groups = 0.
- Incomplete group: push {3, 7, 0} only, hold vblank = 1 for 20 cycles. Result: mem_we stays 0 and the entry remains queued. Then push {4, 0, 1}. Result: writes (3, 7) then (4, 0).
- Group boundary at gate close: queue two 2-entry groups, raise vblank, drop it in the first DRAIN cycle. Result: the first group writes both entries, DONE follows, and the second group waits for the next vblank.
- Full and overflow: with DEPTH = 4, push 4 entries with last = 0. Result: err_ovf = 1, the queue is flushed, wr_ready = 1, and err_ovf stays set until reset_n = 0.
- Reset mid-drain: assert reset_n = 0 during the second write of a 3-entry group. Result: the next cycle has mem_we = 0, and vblank after release produces no writes.
- Simultaneous push and pop: with the queue full of complete groups and vblank = 1, hold wr_valid. Result: a push is accepted every cycle that pops, the groups count stays correct, and no entry is lost or duplicated (scoreboard check).
